// File: rtl/pipelinemath_arbiter_if.sv
// pipelinemath_arbiter_if
//   Request/result bundle for pipelinemath_arbiter.
//   slave  : the arbiter side (takes requests, drives results).
//   master : the requester/consumer side.
//   Signals:
//     req_valid[3:0]   requester i presents an operation
//     req_ready[3:0]   requester i's operation accepted this cycle (one-hot or zero)
//     req_input1..4    packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     result           input1 + input2 * (input4 - input3), 2*DATA_WIDTH wide
//     result_id        requester index that issued the result
//     result_valid     result/result_id valid
//     result_ready     consumer takes the result this cycle
//     op_count         number of delivered results (wraps)
interface pipelinemath_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [3:0]              req_valid;
  logic [3:0]              req_ready;
  logic [4*DATA_WIDTH-1:0] req_input1;
  logic [4*DATA_WIDTH-1:0] req_input2;
  logic [4*DATA_WIDTH-1:0] req_input3;
  logic [4*DATA_WIDTH-1:0] req_input4;
  logic [2*DATA_WIDTH-1:0] result;
  logic [1:0]              result_id;
  logic                    result_valid;
  logic                    result_ready;
  logic [15:0]             op_count;

  modport slave (
    input  req_valid, req_input1, req_input2, req_input3, req_input4, result_ready,
    output req_ready, result, result_id, result_valid, op_count
  );

  modport master (
    output req_valid, req_input1, req_input2, req_input3, req_input4, result_ready,
    input  req_ready, result, result_id, result_valid, op_count
  );
endinterface

// File: rtl/pipelinemath_arbiter.sv
// pipelinemath_arbiter
//   Four requesters share one 3-stage arithmetic pipeline computing
//   result = input1 + input2 * (input4 - input3).
//     stage 1: subtract, capture input1/input2/id
//     stage 2: multiply, carry input1/id
//     stage 3: add into the result register
//   The whole pipe and the arbiter pointer advance together; a held result
//   (result_valid && !result_ready) freezes everything.
//   Ports:
//     clock  sole clock
//     reset  asynchronous, active-low
//     bus    pipelinemath_arbiter_if.slave (requests, result, op_count)
//   Build option:
//     PIPELINEMATH_ARBITER_FIXED_PRIORITY_EN  defined -> lowest-index valid
//     requester always wins; otherwise round-robin starting at a pointer that
//     moves to one past the last granted requester.

// Per-requester operand unpack plus the stage-1 subtraction.
module pipelinemath_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [DATA_WIDTH-1:0] in4,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] diff
);
  assign op1  = in1;
  assign op2  = in2;
  assign diff = in4 - in3;  // wraps modulo 2^DATA_WIDTH
endmodule

module pipelinemath_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  pipelinemath_arbiter_if.slave bus
);
  localparam int NUM_REQ = 4;
  localparam int STAGES  = 3;
  localparam int DW      = DATA_WIDTH;
  localparam int RW      = 2 * DATA_WIDTH;

  typedef struct packed {
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [DW-1:0] diff;
    logic [1:0]    id;
  } s1_t;

  typedef struct packed {
    logic [DW-1:0] in1;
    logic [RW-1:0] prod;
    logic [1:0]    id;
  } s2_t;

  logic [NUM_REQ-1:0][DW-1:0] lane_op1;
  logic [NUM_REQ-1:0][DW-1:0] lane_op2;
  logic [NUM_REQ-1:0][DW-1:0] lane_diff;

  logic [1:0]        gnt_id;
  logic              gnt_any;
  logic              advance;
  logic              xfer;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  s1_t               s1;
  s2_t               s2;
  logic [RW-1:0]     result_q;
  logic [1:0]        id_q;
  logic [15:0]       op_count_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    pipelinemath_arbiter_lane #(.DATA_WIDTH(DW)) u_lane (
      .in1  (bus.req_input1[i*DW +: DW]),
      .in2  (bus.req_input2[i*DW +: DW]),
      .in3  (bus.req_input3[i*DW +: DW]),
      .in4  (bus.req_input4[i*DW +: DW]),
      .op1  (lane_op1[i]),
      .op2  (lane_op2[i]),
      .diff (lane_diff[i])
    );
  end

  // Stage 3 valid is result_valid; a result the consumer refuses stalls all.
  assign advance  = !(vld_q[STAGES] && !bus.result_ready);
  // Gate with reset so req_ready reads 0 while reset is held, even though the
  // stall term alone would allow a grant.
  assign xfer     = gnt_any && advance && reset;
  assign vld_pipe = {vld_q, xfer};

`ifdef PIPELINEMATH_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    // Scan downward so the lowest valid index is the one left standing.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_id  = 2'(k);
      end
    end
  end
`else
  logic [1:0] ptr;
  logic [1:0] srch_idx;

  always_comb begin
    gnt_id   = '0;
    gnt_any  = 1'b0;
    srch_idx = '0;
    // Scan ptr+3 down to ptr so the nearest valid at/after ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      srch_idx = ptr + 2'(k);
      if (bus.req_valid[srch_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = srch_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    ptr <= '0;
    else if (xfer) ptr <= gnt_id + 2'd1;
  end
`endif

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q    <= '0;
      s1       <= '0;
      s2       <= '0;
      result_q <= '0;
      id_q     <= '0;
    end else if (advance) begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (xfer) begin
        s1.in1  <= lane_op1[gnt_id];
        s1.in2  <= lane_op2[gnt_id];
        s1.diff <= lane_diff[gnt_id];
        s1.id   <= gnt_id;
      end
      if (vld_pipe[1]) begin
        s2.in1  <= s1.in1;
        s2.prod <= RW'(s1.in2) * RW'(s1.diff);
        s2.id   <= s1.id;
      end
      // Bubbles leave the last result in place; only result_valid drops.
      if (vld_pipe[2]) begin
        result_q <= RW'(s2.in1) + s2.prod;
        id_q     <= s2.id;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                op_count_q <= '0;
    else if (vld_q[STAGES] && bus.result_ready) op_count_q <= op_count_q + 16'd1;
  end

  assign bus.result       = result_q;
  assign bus.result_id    = id_q;
  assign bus.result_valid = vld_q[STAGES];
  assign bus.op_count     = op_count_q;
endmodule
